// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencer: FSM encodings,
// the per-cycle control bundle, and the canned control patterns.
package pipe_ctrl_pkg;

  localparam int unsigned PC_REG_ID_WIDTH    = 5;
  localparam int unsigned PC_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    PC_RUN      = 2'd0,
    PC_MEM_WAIT = 2'd1,
    PC_ERR      = 2'd2
  } pcState_t;

  typedef struct packed {
    logic pcWen;
    logic wenIfId;
    logic wenIdEx;
    logic wenExMem;
    logic wenMemWb;
    logic flushIfId;
    logic flushIdEx;
    logic flushMemWb;
  } pcCtl_t;

  function automatic pcCtl_t mkCtl(
    input logic pcWen,
    input logic wenIfId,
    input logic wenIdEx,
    input logic wenExMem,
    input logic wenMemWb,
    input logic flushIfId,
    input logic flushIdEx,
    input logic flushMemWb
  );
    pcCtl_t c;
    c.pcWen      = pcWen;
    c.wenIfId    = wenIfId;
    c.wenIdEx    = wenIdEx;
    c.wenExMem   = wenExMem;
    c.wenMemWb   = wenMemWb;
    c.flushIfId  = flushIfId;
    c.flushIdEx  = flushIdEx;
    c.flushMemWb = flushMemWb;
    return c;
  endfunction

  // Flush wins over enable in the pipeline registers, so the enable of a
  // flushed stage is left high where that keeps the pattern uniform.
  localparam pcCtl_t CTL_RESET    = 8'b0000_0111;
  localparam pcCtl_t CTL_ERR      = 8'b0000_0000;
  localparam pcCtl_t CTL_MEM      = 8'b0000_1001;
  localparam pcCtl_t CTL_REDIRECT = 8'b1111_1110;
  localparam pcCtl_t CTL_LOAD_USE = 8'b0011_1010;
  localparam pcCtl_t CTL_FETCH    = 8'b0111_1100;
  localparam pcCtl_t CTL_RUN      = 8'b1111_1000;

endpackage

// File: rtl/Reg.sv
// Generic enabled register with asynchronous active-low reset.
module Reg #(
  parameter int unsigned      Width    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= ResetVal;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the ID-stage sources and a load in EX.
module hazard_detect #(
  parameter int unsigned RegIdWidth = 5
) (
  input  logic [RegIdWidth-1:0] rs1_ID,
  input  logic [RegIdWidth-1:0] rs2_ID,
  input  logic                  rs1_used_ID,
  input  logic                  rs2_used_ID,
  input  logic [RegIdWidth-1:0] rd_EX,
  input  logic                  mem_read_EX,
  input  logic                  valid_EX,
  output logic                  loadUse
);

  logic rdLive;
  logic hit1;
  logic hit2;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign rdLive  = valid_EX && mem_read_EX && (rd_EX != '0);
  assign hit1    = rs1_used_ID && (rs1_ID == rd_EX);
  assign hit2    = rs2_used_ID && (rs2_ID == rd_EX);
  assign loadUse = rdLive && (hit1 || hit2);

endmodule

// File: rtl/pipe_ctrl.sv
// Central 5-stage pipeline sequencer: stall/flush decisions, data-memory
// wait FSM with watchdog, and a saturating stall performance counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned RegIdWidth = PC_REG_ID_WIDTH,
  parameter int unsigned TIMEOUT    = PC_TIMEOUT_DEFAULT,
  parameter int unsigned CntWidth   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegIdWidth-1:0] rs1_ID,
  input  logic [RegIdWidth-1:0] rs2_ID,
  input  logic                  rs1_used_ID,
  input  logic                  rs2_used_ID,
  input  logic [RegIdWidth-1:0] rd_EX,
  input  logic                  mem_read_EX,
  input  logic                  valid_EX,
  input  logic                  redirect_EX,
  input  logic                  ifu_valid,
  input  logic                  mem_req_MEM,
  input  logic                  mem_ready_MEM,
  output logic                  pc_wen,
  output logic                  wen_IF_ID,
  output logic                  wen_ID_EX,
  output logic                  wen_EX_MEM,
  output logic                  wen_MEM_WB,
  output logic                  flush_IF_ID,
  output logic                  flush_ID_EX,
  output logic                  flush_MEM_WB,
  output logic                  mem_timeout,
  output logic [CntWidth-1:0]   stall_cnt
);

  localparam int unsigned WaitWidth = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WaitWidth-1:0] TimeoutVal = WaitWidth'(TIMEOUT);

  pcState_t             state;
  pcCtl_t               ctl;
  logic                 loadUse;
  logic                 memStall;
  logic                 stallAny;
  logic                 waitEn;
  logic [WaitWidth-1:0] waitD;
  logic [WaitWidth-1:0] waitCnt;
  logic                 statEn;
  logic [CntWidth-1:0]  statD;

  hazard_detect #(
    .RegIdWidth(RegIdWidth)
  ) uHazard (
    .rs1_ID      (rs1_ID),
    .rs2_ID      (rs2_ID),
    .rs1_used_ID (rs1_used_ID),
    .rs2_used_ID (rs2_used_ID),
    .rd_EX       (rd_EX),
    .mem_read_EX (mem_read_EX),
    .valid_EX    (valid_EX),
    .loadUse     (loadUse)
  );

  assign memStall = ((state == PC_RUN) && mem_req_MEM && !mem_ready_MEM) ||
                    ((state == PC_MEM_WAIT) && !mem_ready_MEM);

  // Priority chain; reset is folded in so the pipeline is held flushed
  // for as long as rst is low, not only from the next edge.
  always_comb begin
    ctl      = CTL_RUN;
    stallAny = 1'b0;
    if (!rst) begin
      ctl = CTL_RESET;
    end else if (state == PC_ERR) begin
      ctl = CTL_ERR;
    end else if (memStall) begin
      ctl      = CTL_MEM;
      stallAny = 1'b1;
    end else if (redirect_EX) begin
      ctl = CTL_REDIRECT;
    end else if (loadUse) begin
      ctl      = CTL_LOAD_USE;
      stallAny = 1'b1;
    end else if (!ifu_valid) begin
      ctl      = CTL_FETCH;
      stallAny = 1'b1;
    end
  end

  assign pc_wen       = ctl.pcWen;
  assign wen_IF_ID    = ctl.wenIfId;
  assign wen_ID_EX    = ctl.wenIdEx;
  assign wen_EX_MEM   = ctl.wenExMem;
  assign wen_MEM_WB   = ctl.wenMemWb;
  assign flush_IF_ID  = ctl.flushIfId;
  assign flush_ID_EX  = ctl.flushIdEx;
  assign flush_MEM_WB = ctl.flushMemWb;

  // Wait counter: loads 1 on entry to MEM_WAIT and counts each further
  // not-ready cycle; it stops at TIMEOUT, where the FSM takes over.
  always_comb begin
    waitEn = 1'b0;
    waitD  = waitCnt;
    if ((state == PC_RUN) && mem_req_MEM && !mem_ready_MEM) begin
      waitEn = 1'b1;
      waitD  = WaitWidth'(1);
    end else if ((state == PC_MEM_WAIT) && !mem_ready_MEM && (waitCnt != TimeoutVal)) begin
      waitEn = 1'b1;
      waitD  = waitCnt + WaitWidth'(1);
    end
  end

  Reg #(
    .Width    (WaitWidth),
    .ResetVal ('0)
  ) uWaitCnt (
    .clk (clk),
    .rst (rst),
    .en  (waitEn),
    .d   (waitD),
    .q   (waitCnt)
  );

  assign statEn = stallAny && (stall_cnt != '1);
  assign statD  = stall_cnt + CntWidth'(1);

  Reg #(
    .Width    (CntWidth),
    .ResetVal ('0)
  ) uStallCnt (
    .clk (clk),
    .rst (rst),
    .en  (statEn),
    .d   (statD),
    .q   (stall_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= PC_RUN;
      mem_timeout <= 1'b0;
    end else begin
      unique case (state)
        PC_RUN: begin
          if (mem_req_MEM && !mem_ready_MEM) begin
            state <= PC_MEM_WAIT;
          end
        end
        PC_MEM_WAIT: begin
          if (mem_ready_MEM) begin
            state <= PC_RUN;
          end else if (waitCnt == TimeoutVal) begin
            state       <= PC_ERR;
            mem_timeout <= 1'b1;
          end
        end
        PC_ERR: begin
          state <= PC_ERR;
        end
        default: begin
          state <= PC_RUN;
        end
      endcase
    end
  end

endmodule
